pe_rf_writeback: RTL and testbench

Per-lane writeback arbiter that produces the write side of the PE register file: rf_we, rd and rd_v for all 4 lanes. Each lane merges two result sources into its bank's single write port: a non-stallable ALU result and a stallable load-return result buffered in a small per-lane FIFO. It also keeps a 32-bit pending-load scoreboard over all 4x8 registers, used by issue logic for RAW stalls.

---
 rtl/pe_rf_writeback.sv | 114 +++++++++++
 tb/tb_pe_rf_writeback.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_rf_writeback.sv
// Per-lane register-file writeback: ALU results take priority over a small
// load-return FIFO per lane, with a pending-load scoreboard for RAW stalls.
module pe_rf_writeback #(
  parameter int unsigned LD_FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   alu_valid_i,
  input  logic [11:0]  alu_idx_i,
  input  logic [127:0] alu_v_i,
  input  logic [3:0]   ld_valid_i,
  output logic [3:0]   ld_ready_o,
  input  logic [11:0]  ld_idx_i,
  input  logic [127:0] ld_v_i,
  input  logic [3:0]   pend_set_i,
  input  logic [11:0]  pend_idx_i,
  output logic [3:0]   rf_we_o,
  output logic [19:0]  rd_o,
  output logic [127:0] rd_v_o,
  output logic [31:0]  pending_o
);

  localparam int unsigned LANES = 4;
  localparam int unsigned IW    = 3;
  localparam int unsigned DW    = 32;
  localparam int unsigned EW    = IW + DW;
  localparam int unsigned PW    = $clog2(LD_FIFO_DEPTH);
  localparam int unsigned CW    = $clog2(LD_FIFO_DEPTH + 1);

  logic [EW-1:0]            mem_q [LANES][LD_FIFO_DEPTH];
  logic [LANES-1:0][PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LANES-1:0][CW-1:0] cnt_q, cnt_d;
  logic [LANES-1:0]         ready_q, ready_d, we_q, we_d, push, pop;
  logic [LANES-1:0][4:0]    rd_q, rd_d;
  logic [LANES-1:0][DW-1:0] rdv_q, rdv_d;
  logic [LANES-1:0][EW-1:0] head;
  logic [31:0]              pend_q, pend_d;

  // Source select, FIFO bookkeeping and scoreboard update; pending set beats clear
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    we_d    = '0;
    rd_d    = rd_q;
    rdv_d   = rdv_q;
    pend_d  = pend_q;
    push    = '0;
    pop     = '0;
    head    = '0;
    for (int l = 0; l < LANES; l++) begin
      head[l] = mem_q[l][rptr_q[l]];
      push[l] = ld_valid_i[l] & ready_q[l];
      pop[l]  = ~alu_valid_i[l] & (cnt_q[l] != '0);
      if (alu_valid_i[l]) begin
        we_d[l]  = 1'b1;
        rd_d[l]  = {2'(l), alu_idx_i[l*IW +: IW]};
        rdv_d[l] = alu_v_i[l*DW +: DW];
      end else if (pop[l]) begin
        we_d[l]  = 1'b1;
        rd_d[l]  = {2'(l), head[l][EW-1 -: IW]};
        rdv_d[l] = head[l][DW-1:0];
        pend_d[{2'(l), head[l][EW-1 -: IW]}] = 1'b0;
      end
      if (pend_set_i[l]) begin
        pend_d[{2'(l), pend_idx_i[l*IW +: IW]}] = 1'b1;
      end
      if (push[l]) begin
        wptr_d[l] = wptr_q[l] + PW'(1);
      end
      if (pop[l]) begin
        rptr_d[l] = rptr_q[l] + PW'(1);
      end
      cnt_d[l]   = cnt_q[l] + CW'(push[l]) - CW'(pop[l]);
      ready_d[l] = (cnt_d[l] < CW'(LD_FIFO_DEPTH));
    end
  end

  // State registers; FIFO data storage is not reset since count gates it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ready_q <= '0;
      we_q    <= '0;
      rd_q    <= '0;
      rdv_q   <= '0;
      pend_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      rdv_q   <= rdv_d;
      pend_q  <= pend_d;
      for (int l = 0; l < LANES; l++) begin
        if (push[l]) begin
          mem_q[l][wptr_q[l]] <= {ld_idx_i[l*IW +: IW], ld_v_i[l*DW +: DW]};
        end
      end
    end
  end

  assign ld_ready_o = ready_q;
  assign rf_we_o    = we_q;
  assign rd_o       = rd_q;
  assign rd_v_o     = rdv_q;
  assign pending_o  = pend_q;

endmodule

// File: tb/tb_pe_rf_writeback.sv
// Bench for pe_rf_writeback: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pe_rf_writeback;

  localparam int DEPTH = 2;

  logic         clk;
  logic         rst_n;
  logic [3:0]   alu_valid;
  logic [11:0]  alu_idx;
  logic [127:0] alu_v;
  logic [3:0]   ld_valid;
  logic [3:0]   ld_ready;
  logic [11:0]  ld_idx;
  logic [127:0] ld_v;
  logic [3:0]   pend_set;
  logic [11:0]  pend_idx;
  logic [3:0]   rf_we;
  logic [19:0]  rd;
  logic [127:0] rd_v;
  logic [31:0]  pending;

  int n_checks = 0;
  int n_pass   = 0;

  pe_rf_writeback #(.LD_FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid_i(alu_valid),
    .alu_idx_i  (alu_idx),
    .alu_v_i    (alu_v),
    .ld_valid_i (ld_valid),
    .ld_ready_o (ld_ready),
    .ld_idx_i   (ld_idx),
    .ld_v_i     (ld_v),
    .pend_set_i (pend_set),
    .pend_idx_i (pend_idx),
    .rf_we_o    (rf_we),
    .rd_o       (rd),
    .rd_v_o     (rd_v),
    .pending_o  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endfunction

  // Reference model: one queue per lane, outputs derived from the selection rules
  logic [34:0]  q [4][$];
  logic [3:0]   exp_we, exp_ready;
  logic [4:0]   exp_rd [4];
  logic [31:0]  exp_rdv [4];
  logic [31:0]  exp_pend;
  bit           model_ok = 1'b0;

  always @(posedge clk) begin
    logic [34:0] e;
    logic [31:0] pn;
    if (!rst_n) begin
      for (int l = 0; l < 4; l++) begin
        q[l].delete();
        exp_rd[l]  = '0;
        exp_rdv[l] = '0;
      end
      exp_we    = '0;
      exp_ready = '0;
      exp_pend  = '0;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      pn = exp_pend;
      for (int l = 0; l < 4; l++) begin
        if (alu_valid[l]) begin
          exp_we[l]  = 1'b1;
          exp_rd[l]  = {2'(l), alu_idx[l*3 +: 3]};
          exp_rdv[l] = alu_v[l*32 +: 32];
        end else if (q[l].size() > 0) begin
          e = q[l].pop_front();
          exp_we[l]  = 1'b1;
          exp_rd[l]  = {2'(l), e[34:32]};
          exp_rdv[l] = e[31:0];
          pn[l*8 + int'(e[34:32])] = 1'b0;
        end else begin
          exp_we[l] = 1'b0;
        end
        if (ld_valid[l] && exp_ready[l]) q[l].push_back({ld_idx[l*3 +: 3], ld_v[l*32 +: 32]});
        if (pend_set[l]) pn[l*8 + int'(pend_idx[l*3 +: 3])] = 1'b1;
        exp_ready[l] = (q[l].size() < DEPTH);
      end
      exp_pend = pn;
    end
    if (model_ok) begin
      #1;
      chk("model_rf_we", 128'(rf_we), 128'(exp_we));
      chk("model_ld_ready", 128'(ld_ready), 128'(exp_ready));
      chk("model_pending", 128'(pending), 128'(exp_pend));
      for (int l = 0; l < 4; l++) begin
        chk("model_rd", 128'(rd[l*5 +: 5]), 128'(exp_rd[l]));
        chk("model_rd_v", 128'(rd_v[l*32 +: 32]), 128'(exp_rdv[l]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    alu_valid = '0;
    ld_valid  = '0;
    pend_set  = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 4'hF; ld_valid = 4'hF; pend_set = 4'hF;
    alu_idx = 12'hFFF; ld_idx = 12'hAAA; pend_idx = 12'h555;
    alu_v = {4{32'hCAFE_F00D}}; ld_v = {4{32'h0BAD_0BAD}};
    repeat (3) tick();
    chk("reset_rf_we", 128'(rf_we), 128'h0);
    chk("reset_ld_ready", 128'(ld_ready), 128'h0);
    chk("reset_pending", 128'(pending), 128'h0);

    rst_n = 1'b1; idle();
    tick();
    chk("release_ld_ready", 128'(ld_ready), 128'hF);

    // ALU path on lane 2
    alu_valid = 4'b0100; alu_idx[8:6] = 3'd5; alu_v[95:64] = 32'hDEADBEEF;
    tick(); idle();
    chk("alu_rf_we", 128'(rf_we), 128'h4);
    chk("alu_rd2", 128'(rd[14:10]), 128'h15);
    chk("alu_rdv2", 128'(rd_v[95:64]), 128'hDEADBEEF);

    // Load path with scoreboard on lane 1
    pend_set = 4'b0010; pend_idx[5:3] = 3'd3;
    tick(); idle();
    chk("pend_bit11_set", 128'(pending[11]), 128'h1);
    ld_valid = 4'b0010; ld_idx[5:3] = 3'd3; ld_v[63:32] = 32'h12345678;
    tick(); idle();
    chk("load_t1_no_we", 128'(rf_we[1]), 128'h0);
    tick();
    chk("load_t2_we", 128'(rf_we[1]), 128'h1);
    chk("load_t2_rd1", 128'(rd[9:5]), 128'h0B);
    chk("load_t2_rdv1", 128'(rd_v[63:32]), 128'h12345678);
    chk("load_t2_bit11_clr", 128'(pending[11]), 128'h0);

    // Starvation and backpressure on lane 0
    alu_valid = 4'b0001; alu_idx[2:0] = 3'd6; alu_v[31:0] = 32'h11110000;
    ld_valid = 4'b0001; ld_idx[2:0] = 3'd1; ld_v[31:0] = 32'hA0A0_0001;
    tick();
    ld_idx[2:0] = 3'd2; ld_v[31:0] = 32'hB0B0_0002;
    tick();
    chk("starve_ready_low", 128'(ld_ready[0]), 128'h0);
    ld_idx[2:0] = 3'd4; ld_v[31:0] = 32'hC0C0_0003;
    tick(); tick();
    chk("starve_ready_still_low", 128'(ld_ready[0]), 128'h0);
    chk("starve_alu_rdv0", 128'(rd_v[31:0]), 128'h11110000);
    idle();
    tick();
    chk("drain1_we", 128'(rf_we[0]), 128'h1);
    chk("drain1_rd0", 128'(rd[4:0]), 128'h01);
    chk("drain1_rdv0", 128'(rd_v[31:0]), 128'hA0A00001);
    tick();
    chk("drain2_rd0", 128'(rd[4:0]), 128'h02);
    chk("drain2_rdv0", 128'(rd_v[31:0]), 128'hB0B00002);
    chk("drain_ready_high", 128'(ld_ready[0]), 128'h1);
    tick();
    chk("drain_done_we", 128'(rf_we[0]), 128'h0);

    // Set/clear collision on lane 3, idx 7
    pend_set = 4'b1000; pend_idx[11:9] = 3'd7;
    tick(); idle();
    ld_valid = 4'b1000; ld_idx[11:9] = 3'd7; ld_v[127:96] = 32'h77777777;
    tick(); idle();
    pend_set = 4'b1000; pend_idx[11:9] = 3'd7;
    tick(); idle();
    chk("collide_we3", 128'(rf_we[3]), 128'h1);
    chk("collide_bit31", 128'(pending[31]), 128'h1);

    // Mid-operation reset with lane 0 FIFO full
    alu_valid = 4'b0001; alu_idx[2:0] = 3'd0;
    pend_set = 4'b0001; pend_idx[2:0] = 3'd0;
    ld_valid = 4'b0001; ld_idx[2:0] = 3'd5; ld_v[31:0] = 32'h55555555;
    tick();
    pend_idx[2:0] = 3'd1; ld_idx[2:0] = 3'd6; ld_v[31:0] = 32'h66666666;
    tick();
    ld_valid = '0; pend_idx[2:0] = 3'd2;
    tick();
    pend_idx[2:0] = 3'd3;
    tick();
    chk("pre_reset_pend_low", 128'(pending[3:0]), 128'hF);
    chk("pre_reset_ready0", 128'(ld_ready[0]), 128'h0);
    rst_n = 1'b0; idle();
    tick();
    chk("midrst_we", 128'(rf_we), 128'h0);
    chk("midrst_pending", 128'(pending), 128'h0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_we", 128'(rf_we), 128'h0);
    chk("post_rst_ready", 128'(ld_ready), 128'hF);
    tick();
    chk("post_rst_no_ghost", 128'(rf_we), 128'h0);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      alu_valid = 4'($urandom) & 4'($urandom);
      ld_valid  = 4'($urandom);
      pend_set  = 4'($urandom);
      alu_idx   = 12'($urandom);
      ld_idx    = 12'($urandom);
      pend_idx  = 12'($urandom);
      alu_v     = {$urandom, $urandom, $urandom, $urandom};
      ld_v      = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    rst_n = 1'b1; idle();
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
